// File: rtl/cam_pkg.sv
// cam_pkg: shared FSM states, byte-order codes and pixel width helper for the camera capture slice
package cam_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, ACTIVE} state_t;
  localparam int MSB_FIRST = 0;
  localparam int LSB_FIRST = 1;
  function automatic int pix_w(input int bpp);
    return 8 * bpp;
  endfunction
endpackage

// File: rtl/camera_capture_param_if.sv
// camera_capture_param_if: camera bus inputs and pixel stream outputs of the capture block
interface camera_capture_param_if #(
  parameter int BYTES_PER_PIX = 2,
  parameter int X_BITS = 10,
  parameter int Y_BITS = 10,
  parameter int FCNT_BITS = 8
);
  logic i_vsync;
  logic i_href;
  logic [7:0] i_data;
  logic i_enable;
  logic [cam_pkg::pix_w(BYTES_PER_PIX)-1:0] o_pixelOut;
  logic o_pixelValid;
  logic [X_BITS-1:0] o_xIndex;
  logic [Y_BITS-1:0] o_yIndex;
  logic o_frameStart;
  logic o_frameDone;
  logic o_lineErr;
  logic o_frameErr;
  logic [FCNT_BITS-1:0] o_frameCount;
  modport master (
    output i_vsync, i_href, i_data, i_enable,
    input o_pixelOut, o_pixelValid, o_xIndex, o_yIndex, o_frameStart, o_frameDone, o_lineErr, o_frameErr, o_frameCount
  );
  modport slave (
    input i_vsync, i_href, i_data, i_enable,
    output o_pixelOut, o_pixelValid, o_xIndex, o_yIndex, o_frameStart, o_frameDone, o_lineErr, o_frameErr, o_frameCount
  );
endinterface

// File: rtl/cam_byte_packer.sv
// cam_byte_packer: tracks byte phase and assembles 1- or 2-byte pixel words with a raw completion strobe
module cam_byte_packer #(
  parameter int BYTES_PER_PIX = 2,
  parameter int BYTE_ORDER = 0
) (
  input logic clk,
  input logic rst,
  input logic take,
  input logic [7:0] data,
  output logic phase,
  output logic stb,
  output logic [cam_pkg::pix_w(BYTES_PER_PIX)-1:0] word
);
  assign stb = take && (BYTES_PER_PIX == 1 || phase);
  // Phase toggles per accepted byte in 2-byte mode and falls back to 0 whenever bytes stop
  always_ff @(posedge clk or posedge rst)
    if (rst) phase <= 1'b0;
    else phase <= take && BYTES_PER_PIX == 2 && !phase;
  if (BYTES_PER_PIX == 1) begin : g_one
    assign word = data;
  end else begin : g_two
    logic [7:0] first;
    // Hold the first byte of a pair until its partner arrives
    always_ff @(posedge clk or posedge rst)
      if (rst) first <= '0;
      else if (take && !phase) first <= data;
    assign word = BYTE_ORDER == cam_pkg::MSB_FIRST ? {first, data} : {data, first};
  end
endmodule

// File: rtl/camera_capture_param.sv
// camera_capture_param: DVP capture front end with framing FSM, decimation, range checks and integrity errors
module camera_capture_param
  import cam_pkg::*;
#(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240,
  parameter int BYTES_PER_PIX = 2,
  parameter int BYTE_ORDER = 0,
  parameter int DECIM = 1,
  parameter int X_BITS = 10,
  parameter int Y_BITS = 10,
  parameter int FCNT_BITS = 8
) (
  input logic i_pclk,
  input logic i_reset,
  camera_capture_param_if.slave bus
);
  localparam logic [15:0] W16 = 16'(IMG_W);
  localparam logic [15:0] H16 = 16'(IMG_H);
  state_t state, state_n;
  logic vsync_d, href_d, primed, line_has;
  logic vs_rise, vs_fall, href_fall, active, take, stb, phase;
  logic frame_start, frame_done, line_end, emit;
  logic [15:0] col, row, xo, yo;
  logic [pix_w(BYTES_PER_PIX)-1:0] word;
  assign vs_rise = primed && bus.i_vsync && !vsync_d;
  assign vs_fall = primed && !bus.i_vsync && vsync_d;
  assign href_fall = !bus.i_href && href_d;
  assign active = state == ACTIVE;
  assign take = active && bus.i_href && !vs_rise;
  assign line_end = active && href_fall && !vs_rise && line_has;
  assign emit = stb && col < W16 && row < H16 && (DECIM == 1 || (!col[0] && !row[0]));
  assign xo = DECIM == 2 ? col >> 1 : col;
  assign yo = DECIM == 2 ? row >> 1 : row;
  cam_byte_packer #(.BYTES_PER_PIX(BYTES_PER_PIX), .BYTE_ORDER(BYTE_ORDER)) packer (
    .clk(i_pclk),
    .rst(i_reset),
    .take(take),
    .data(bus.i_data),
    .phase(phase),
    .stb(stb),
    .word(word)
  );
  // A VSYNC rise always closes the frame; enable at that instant only decides whether to re-arm
  always_comb begin
    state_n = vs_rise ? (bus.i_enable ? ARMED : IDLE) : (state == ARMED && vs_fall) ? ACTIVE : state;
    frame_start = state == ARMED && vs_fall;
    frame_done = state == ACTIVE && vs_rise;
  end
  // FSM state, sync history and input-space column/row counters
  always_ff @(posedge i_pclk or posedge i_reset)
    if (i_reset) begin
      state <= IDLE;
      vsync_d <= 1'b0;
      href_d <= 1'b0;
      primed <= 1'b0;
      col <= '0;
      row <= '0;
      line_has <= 1'b0;
    end else begin
      state <= state_n;
      vsync_d <= bus.i_vsync;
      href_d <= bus.i_href;
      primed <= 1'b1;
      if (frame_start) begin
        col <= '0;
        row <= '0;
        line_has <= 1'b0;
      end else if (line_end) begin
        col <= '0;
        row <= row + 16'd1;
        line_has <= 1'b0;
      end else begin
        if (stb) col <= col + 16'd1;
        if (take) line_has <= 1'b1;
      end
    end
  // Registered pixel stream and status pulses; a partial line cut by VSYNC still counts as a line
  always_ff @(posedge i_pclk or posedge i_reset)
    if (i_reset) begin
      bus.o_pixelOut <= '0;
      bus.o_pixelValid <= 1'b0;
      bus.o_xIndex <= '0;
      bus.o_yIndex <= '0;
      bus.o_frameStart <= 1'b0;
      bus.o_frameDone <= 1'b0;
      bus.o_lineErr <= 1'b0;
      bus.o_frameErr <= 1'b0;
      bus.o_frameCount <= '0;
    end else begin
      bus.o_pixelValid <= emit;
      if (emit) begin
        bus.o_pixelOut <= word;
        bus.o_xIndex <= X_BITS'(xo);
        bus.o_yIndex <= Y_BITS'(yo);
      end
      bus.o_frameStart <= frame_start;
      bus.o_frameDone <= frame_done;
      bus.o_lineErr <= line_end && (col != W16 || phase);
      bus.o_frameErr <= frame_done && row + {15'd0, line_has} != H16;
      if (frame_done) bus.o_frameCount <= bus.o_frameCount + 1'b1;
    end
endmodule

// File: tb/tb_camera_capture_param.sv
// tb_camera_capture_param: directed checks of four capture configurations driven by one shared camera bus
module tb_camera_capture_param;
  logic clk = 1'b0, rst = 1'b1, vsync = 1'b0, href = 1'b0, en = 1'b1;
  logic [7:0] data = 8'h00;
  int total = 0, bad = 0, exp_fc = 0;
  int nstb[4], nle[4], nfd[4], nfe[4], nfs[4], run[4], mrun[4];
  logic [15:0] fpix[4], lpix[4];
  logic [9:0] fx[4], fy[4], lx[4], ly[4], mx[4], my[4];
  always #5 clk = ~clk;
  camera_capture_param_if #(.BYTES_PER_PIX(2)) ia ();
  camera_capture_param_if #(.BYTES_PER_PIX(2)) ib ();
  camera_capture_param_if #(.BYTES_PER_PIX(1)) ic ();
  camera_capture_param_if #(.BYTES_PER_PIX(2)) id ();
  assign ia.i_vsync = vsync; assign ia.i_href = href; assign ia.i_data = data; assign ia.i_enable = en;
  assign ib.i_vsync = vsync; assign ib.i_href = href; assign ib.i_data = data; assign ib.i_enable = en;
  assign ic.i_vsync = vsync; assign ic.i_href = href; assign ic.i_data = data; assign ic.i_enable = en;
  assign id.i_vsync = vsync; assign id.i_href = href; assign id.i_data = data; assign id.i_enable = en;
  camera_capture_param #(.IMG_W(8), .IMG_H(4), .BYTES_PER_PIX(2), .BYTE_ORDER(0), .DECIM(1)) ua (.i_pclk(clk), .i_reset(rst), .bus(ia.slave));
  camera_capture_param #(.IMG_W(8), .IMG_H(4), .BYTES_PER_PIX(2), .BYTE_ORDER(1), .DECIM(1)) ub (.i_pclk(clk), .i_reset(rst), .bus(ib.slave));
  camera_capture_param #(.IMG_W(8), .IMG_H(4), .BYTES_PER_PIX(1), .BYTE_ORDER(0), .DECIM(1)) uc (.i_pclk(clk), .i_reset(rst), .bus(ic.slave));
  camera_capture_param #(.IMG_W(8), .IMG_H(4), .BYTES_PER_PIX(2), .BYTE_ORDER(0), .DECIM(2)) ud (.i_pclk(clk), .i_reset(rst), .bus(id.slave));

  task automatic mon(input int k, input logic v, input logic [15:0] p, input logic [9:0] x, input logic [9:0] y,
                     input logic le, input logic fs, input logic fd, input logic fe);
    if (v) begin
      nstb[k]++;
      if (nstb[k] == 1) begin fpix[k] = p; fx[k] = x; fy[k] = y; end
      lpix[k] = p; lx[k] = x; ly[k] = y;
      if (x > mx[k]) mx[k] = x;
      if (y > my[k]) my[k] = y;
      run[k]++;
      if (run[k] > mrun[k]) mrun[k] = run[k];
    end else run[k] = 0;
    if (le) nle[k]++;
    if (fs) nfs[k]++;
    if (fd) nfd[k]++;
    if (fe) nfe[k]++;
  endtask

  always @(negedge clk) begin
    mon(0, ia.o_pixelValid, ia.o_pixelOut, ia.o_xIndex, ia.o_yIndex, ia.o_lineErr, ia.o_frameStart, ia.o_frameDone, ia.o_frameErr);
    mon(1, ib.o_pixelValid, ib.o_pixelOut, ib.o_xIndex, ib.o_yIndex, ib.o_lineErr, ib.o_frameStart, ib.o_frameDone, ib.o_frameErr);
    mon(2, ic.o_pixelValid, {8'h00, ic.o_pixelOut}, ic.o_xIndex, ic.o_yIndex, ic.o_lineErr, ic.o_frameStart, ic.o_frameDone, ic.o_frameErr);
    mon(3, id.o_pixelValid, id.o_pixelOut, id.o_xIndex, id.o_yIndex, id.o_lineErr, id.o_frameStart, id.o_frameDone, id.o_frameErr);
  end

  task automatic clr();
    for (int k = 0; k < 4; k++) begin
      nstb[k] = 0; nle[k] = 0; nfd[k] = 0; nfe[k] = 0; nfs[k] = 0; run[k] = 0; mrun[k] = 0;
      fpix[k] = '0; lpix[k] = '0; fx[k] = '0; fy[k] = '0; lx[k] = '0; ly[k] = '0; mx[k] = '0; my[k] = '0;
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_line(input int l, input int nb, input int fix);
    href = 1'b1;
    for (int i = 0; i < nb; i++) begin
      data = fix >= 0 ? 8'(fix) : (i % 2 == 0 ? 8'h12 + 8'(l * 16) : 8'h34 + 8'(i / 2));
      step(1);
    end
    href = 1'b0;
    data = 8'h00;
    step(4);
  endtask

  task automatic send_frame(input int nl, input int nb, input int fix, input int sl, input int snb, input int drop);
    vsync = 1'b1;
    step(3);
    vsync = 1'b0;
    step(3);
    for (int l = 0; l < nl; l++) begin
      if (l == drop) en = 1'b0;
      send_line(l, l == sl ? snb : nb, fix);
    end
    vsync = 1'b1;
    step(3);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    total++; if (ia.o_pixelValid !== 1'b0) begin bad++; $display("FAIL reset_valid got %0b want 0", ia.o_pixelValid); end
    total++; if (ia.o_pixelOut !== 16'h0) begin bad++; $display("FAIL reset_pixel got %h want 0000", ia.o_pixelOut); end
    total++; if (ia.o_xIndex !== 10'd0 || ia.o_yIndex !== 10'd0) begin bad++; $display("FAIL reset_index got x=%0d y=%0d want 0 0", ia.o_xIndex, ia.o_yIndex); end
    total++; if ({ia.o_frameStart, ia.o_frameDone, ia.o_lineErr, ia.o_frameErr} !== 4'b0) begin bad++; $display("FAIL reset_pulses got %b want 0000", {ia.o_frameStart, ia.o_frameDone, ia.o_lineErr, ia.o_frameErr}); end
    total++; if (ia.o_frameCount !== 8'd0) begin bad++; $display("FAIL reset_fcount got %0d want 0", ia.o_frameCount); end
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_frame();
    clr();
    send_frame(4, 16, -1, -1, 0, -1);
    exp_fc++;
    total++; if (nstb[0] !== 32) begin bad++; $display("FAIL frame_strobes got %0d want 32", nstb[0]); end
    total++; if (fpix[0] !== 16'h1234 || fx[0] !== 10'd0 || fy[0] !== 10'd0) begin bad++; $display("FAIL frame_first got %h x=%0d y=%0d want 1234 0 0", fpix[0], fx[0], fy[0]); end
    total++; if (lpix[0] !== 16'h423B || lx[0] !== 10'd7 || ly[0] !== 10'd3) begin bad++; $display("FAIL frame_last got %h x=%0d y=%0d want 423b 7 3", lpix[0], lx[0], ly[0]); end
    total++; if (nfs[0] !== 1 || nfd[0] !== 1 || nfe[0] !== 0 || nle[0] !== 0) begin bad++; $display("FAIL frame_pulses got start=%0d done=%0d ferr=%0d lerr=%0d want 1 1 0 0", nfs[0], nfd[0], nfe[0], nle[0]); end
    total++; if (ia.o_frameCount !== 8'(exp_fc)) begin bad++; $display("FAIL frame_count got %0d want %0d", ia.o_frameCount, exp_fc); end
    total++; if (mrun[0] !== 1) begin bad++; $display("FAIL frame_rate got run=%0d want 1", mrun[0]); end
    total++; if (fpix[1] !== 16'h3412) begin bad++; $display("FAIL lsb_first got %h want 3412", fpix[1]); end
    total++; if (nstb[3] !== 8 || mx[3] !== 10'd3 || my[3] !== 10'd1) begin bad++; $display("FAIL decim_span got n=%0d maxx=%0d maxy=%0d want 8 3 1", nstb[3], mx[3], my[3]); end
    total++; if (lpix[3] !== 16'h323A || nle[3] !== 0 || nfe[3] !== 0) begin bad++; $display("FAIL decim_last got %h lerr=%0d ferr=%0d want 323a 0 0", lpix[3], nle[3], nfe[3]); end
  endtask

  task automatic test_byte_mode();
    clr();
    send_frame(4, 8, 'hA5, -1, 0, -1);
    exp_fc++;
    total++; if (nstb[2] !== 32 || lpix[2] !== 16'h00A5) begin bad++; $display("FAIL byte_mode got n=%0d pix=%h want 32 00a5", nstb[2], lpix[2]); end
    total++; if (mrun[2] !== 8) begin bad++; $display("FAIL byte_rate got run=%0d want 8", mrun[2]); end
    total++; if (nle[2] !== 0 || nfe[2] !== 0 || nfd[2] !== 1) begin bad++; $display("FAIL byte_status got lerr=%0d ferr=%0d done=%0d want 0 0 1", nle[2], nfe[2], nfd[2]); end
    total++; if (nle[0] !== 4) begin bad++; $display("FAIL short_lines got lerr=%0d want 4", nle[0]); end
  endtask

  task automatic test_malformed();
    clr();
    send_frame(4, 16, -1, 0, 18, -1);
    exp_fc++;
    total++; if (nstb[0] !== 32 || mx[0] !== 10'd7 || nle[0] !== 1 || nfe[0] !== 0) begin bad++; $display("FAIL long_line got n=%0d maxx=%0d lerr=%0d ferr=%0d want 32 7 1 0", nstb[0], mx[0], nle[0], nfe[0]); end
    clr();
    send_frame(4, 16, -1, 1, 15, -1);
    exp_fc++;
    total++; if (nstb[0] !== 31 || nle[0] !== 1) begin bad++; $display("FAIL odd_line got n=%0d lerr=%0d want 31 1", nstb[0], nle[0]); end
    clr();
    send_frame(3, 16, -1, -1, 0, -1);
    exp_fc++;
    total++; if (nfd[0] !== 1 || nfe[0] !== 1 || nle[0] !== 0) begin bad++; $display("FAIL short_frame got done=%0d ferr=%0d lerr=%0d want 1 1 0", nfd[0], nfe[0], nle[0]); end
    total++; if (ia.o_frameCount !== 8'(exp_fc)) begin bad++; $display("FAIL malformed_count got %0d want %0d", ia.o_frameCount, exp_fc); end
  endtask

  task automatic test_enable();
    clr();
    send_frame(4, 16, -1, -1, 0, 2);
    exp_fc++;
    total++; if (nstb[0] !== 32 || nfd[0] !== 1 || ia.o_frameCount !== 8'(exp_fc)) begin bad++; $display("FAIL drop_enable got n=%0d done=%0d cnt=%0d want 32 1 %0d", nstb[0], nfd[0], ia.o_frameCount, exp_fc); end
    clr();
    send_frame(4, 16, -1, -1, 0, -1);
    total++; if (nstb[0] !== 0 || nfs[0] !== 0 || nfd[0] !== 0) begin bad++; $display("FAIL disabled_frame got n=%0d start=%0d done=%0d want 0 0 0", nstb[0], nfs[0], nfd[0]); end
    en = 1'b1;
    clr();
    send_frame(4, 16, -1, -1, 0, -1);
    total++; if (nstb[0] !== 0 || nfs[0] !== 0) begin bad++; $display("FAIL unarmed_frame got n=%0d start=%0d want 0 0", nstb[0], nfs[0]); end
    clr();
    send_frame(4, 16, -1, -1, 0, -1);
    exp_fc++;
    total++; if (nstb[0] !== 32 || nfs[0] !== 1 || ia.o_frameCount !== 8'(exp_fc)) begin bad++; $display("FAIL rearmed_frame got n=%0d start=%0d cnt=%0d want 32 1 %0d", nstb[0], nfs[0], ia.o_frameCount, exp_fc); end
  endtask

  task automatic test_reset_midline();
    vsync = 1'b0;
    step(3);
    href = 1'b1;
    for (int i = 0; i < 6; i++) begin data = 8'h55 + 8'(i); step(1); end
    rst = 1'b1;
    #1;
    total++; if (ia.o_pixelOut !== 16'h0 || ia.o_xIndex !== 10'd0 || ia.o_pixelValid !== 1'b0) begin bad++; $display("FAIL async_reset_pixel got %h x=%0d v=%0b want 0000 0 0", ia.o_pixelOut, ia.o_xIndex, ia.o_pixelValid); end
    total++; if (ia.o_frameCount !== 8'd0) begin bad++; $display("FAIL async_reset_count got %0d want 0", ia.o_frameCount); end
    step(1);
    rst = 1'b0;
    clr();
    for (int i = 0; i < 6; i++) begin data = 8'h66 + 8'(i); step(1); end
    href = 1'b0;
    step(4);
    total++; if (nstb[0] !== 0 || nfs[0] !== 0) begin bad++; $display("FAIL post_reset_idle got n=%0d start=%0d want 0 0", nstb[0], nfs[0]); end
    clr();
    send_frame(4, 16, -1, -1, 0, -1);
    total++; if (nstb[0] !== 32 || ia.o_frameCount !== 8'd1) begin bad++; $display("FAIL post_reset_frame got n=%0d cnt=%0d want 32 1", nstb[0], ia.o_frameCount); end
  endtask

  initial begin
    clr();
    test_reset();
    test_frame();
    test_byte_mode();
    test_malformed();
    test_enable();
    test_reset_midline();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/camera_capture_param.md
Name: camera_capture_param

Overview:
- Parametrised DVP-style camera capture front end; successor to the fixed 320x240 RGB565 cameraRead.
- Samples an 8-bit parallel camera bus (VSYNC/HREF/data) on the pixel clock.
- Packs 1 or 2 bytes per pixel in either byte order, with optional 2:1 decimation.
- Emits pixels with x/y indices, frame markers, line/frame integrity errors and a frame counter to the downstream line buffer / CNN preprocessor.

Parameters:
- IMG_W, 320, expected active pixels per line (input space).
- IMG_H, 240, expected active lines per frame (input space).
- BYTES_PER_PIX, 2, 1 = grayscale/raw8, 2 = RGB565/YUV422 word.
- BYTE_ORDER, 0, 0 = first byte is MSB, 1 = first byte is LSB (2-byte mode only).
- DECIM, 1, 1 = full resolution, 2 = keep even columns and even rows only.
- X_BITS, 10, width of o_xIndex.
- Y_BITS, 10, width of o_yIndex.
- FCNT_BITS, 8, width of o_frameCount.

Ports:
- i_pclk  in  1  camera pixel clock; all logic on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_vsync  in  1  vertical sync; rising edge = frame boundary.
- i_href  in  1  line valid; bytes sampled while high.
- i_data  in  8  camera byte.
- i_enable  in  1  capture enable; sampled only at frame boundaries.
- o_pixelOut  out  8*BYTES_PER_PIX  assembled pixel.
- o_pixelValid  out  1  one-cycle strobe per accepted output pixel.
- o_xIndex  out  X_BITS  output-space column of o_pixelOut.
- o_yIndex  out  Y_BITS  output-space row of o_pixelOut.
- o_frameStart  out  1  one-cycle pulse on VSYNC fall when a frame is armed.
- o_frameDone  out  1  one-cycle pulse at VSYNC rise ending a captured frame.
- o_lineErr  out  1  one-cycle pulse on a malformed line.
- o_frameErr  out  1  one-cycle pulse with o_frameDone if the line count is not IMG_H.
- o_frameCount  out  FCNT_BITS  count of completed frames, wraps modulo 2^FCNT_BITS.

Behaviour:
- Reset: all outputs 0, FSM IDLE, byte phase 0, counters 0. Asynchronous assert; released state takes effect at the next edge.
- VSYNC and HREF edges are detected against a one-cycle registered copy. The first edge after reset is never treated as a VSYNC rise.
- FSM transitions:
  - IDLE -> ARMED on VSYNC rise with i_enable=1.
  - ARMED -> ACTIVE on VSYNC fall; pulse o_frameStart, clear line and pixel counters.
  - ACTIVE -> ARMED on VSYNC rise with i_enable=1; pulse o_frameDone, compare line count to IMG_H and set o_frameErr, increment o_frameCount.
  - ACTIVE -> IDLE on VSYNC rise with i_enable=0; same done/err/count actions.
- Enable gating: i_enable deasserted mid-frame does not truncate the current frame.
- Byte packing (ACTIVE and i_href=1 only):
  - Phase toggles each sampled byte (2-byte mode) and is cleared while i_href=0.
  - A pixel completes on the phase-1 byte; in 1-byte mode every byte completes a pixel.
  - BYTE_ORDER=0: {first, second}. BYTE_ORDER=1: {second, first}.
- Latency: o_pixelValid, o_pixelOut and the indices are registered and high in the cycle after the edge that sampled the completing byte. At most one pixel per 2 cycles in 2-byte mode, 1 per cycle in 1-byte mode.
- Column counter counts completed input pixels in the line. Row counter increments on each HREF fall that ended a line containing at least one byte.
- Decimation, DECIM=2: a pixel is emitted only when both the input column and row are even. Output indices are input/2.
- Out-of-range:
  - Input column >= IMG_W or row >= IMG_H: pixel suppressed. One o_lineErr pulse for a column overflow, none for row overflow (reported via o_frameErr).
- HREF fall checks:
  - Column count != IMG_W: o_lineErr.
  - Phase=1 (dangling half pixel): half byte dropped, o_lineErr.
  - Multiple errors on one line produce a single pulse.
- HREF high outside ACTIVE: ignored, no errors.
- Simultaneous VSYNC rise and HREF high: VSYNC wins; the partial line is discarded and counted in the line count.
- o_pixelOut holds its last value between strobes.

Decomposition:
- Package cam_pkg holds:
  - FSM state enum (IDLE, ARMED, ACTIVE).
  - BYTE_ORDER constants (MSB_FIRST=0, LSB_FIRST=1).
  - Helper function for the pixel word width.
- One sub-module, cam_byte_packer: phase tracking, byte order and word assembly, emitting a raw pixel strobe.
- Top level holds the FSM, counters, decimation, range checks and error logic.

Test Plan:
- IMG_W=8, IMG_H=4, 2-byte mode; lines with bytes (0x12,0x34)… -> first o_pixelOut=0x1234 at x=0,y=0; last at x=7,y=3. Next VSYNC rise -> o_frameDone=1, o_frameErr=0, o_frameCount=1.
- BYTE_ORDER=1, bytes 0x12,0x34 -> o_pixelOut=0x3412. BYTES_PER_PIX=1, bytes 0xA5 -> 0xA5 strobed every cycle.
- Malformed lines:
  - 9-pixel line -> 8 strobes, max x=7, one o_lineErr.
  - 15-byte line -> 7 strobes, one o_lineErr.
  - 3-line frame -> o_frameErr=1 with o_frameDone.
- DECIM=2, 8x4 frame -> 8 strobes, x 0..3, y 0..1; no errors.
- i_enable dropped mid-frame -> frame completes, o_frameCount increments. Following frame -> no strobes and no o_frameStart until i_enable=1 at a VSYNC rise.
- i_reset pulsed mid-line -> all outputs 0 immediately. Further bytes are ignored until VSYNC rise then fall; o_frameCount restarts at 0.
